// File: rtl/key_schedule_store_if.sv
`default_nettype none
// ============================================================================
// key_schedule_store_if : key-load and round-key read bus of key_schedule_store
// Revision: 1.0
// ============================================================================
interface key_schedule_store_if;
  logic                  key_load_i;
  logic [127:0]          cipher_key_i;
  logic                  key_ready_o;
  logic                  rk_req_i;
  logic [3:0]            rk_round_i;
  logic                  rk_reverse_i;
  logic [0:3][31:0]      round_key_o;
  logic                  rk_valid_o;

  modport slave (
    input  key_load_i, cipher_key_i, rk_req_i, rk_round_i, rk_reverse_i,
    output key_ready_o, round_key_o, rk_valid_o
  );

  modport master (
    output key_load_i, cipher_key_i, rk_req_i, rk_round_i, rk_reverse_i,
    input  key_ready_o, round_key_o, rk_valid_o
  );
endinterface
`default_nettype wire

// File: rtl/key_schedule_store.sv
`default_nettype none
// ============================================================================
// key_schedule_store : AES-128 key expansion, one round per clock, into an
//                      11-entry round-key file read in forward or reverse order
// Revision: 1.0
// ============================================================================
module key_schedule_store #(
  parameter int NUM_ROUNDS = 10
) (
  input wire                  clk,
  input wire                  n_rst,
  key_schedule_store_if.slave kif
);

  if (NUM_ROUNDS != 10) begin : g_bad_num_rounds
    $error("key_schedule_store: only NUM_ROUNDS = 10 (AES-128) is supported");
  end

  localparam logic [3:0] c_LAST = 4'(NUM_ROUNDS);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_READY  = 2'd2
  } state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return c_SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    logic [7:0] r;
    case (n)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [0:3][31:0] next_round(input logic [0:3][31:0] p,
                                                  input logic [7:0]       rc);
    logic [31:0]      t;
    logic [0:3][31:0] n;
    t    = {sbox(p[3][23:16]), sbox(p[3][15:8]), sbox(p[3][7:0]), sbox(p[3][31:24])}
           ^ {rc, 24'h000000};
    n[0] = p[0] ^ t;
    n[1] = p[1] ^ n[0];
    n[2] = p[2] ^ n[1];
    n[3] = p[3] ^ n[2];
    return n;
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [0:3][31:0] rf_q [0:NUM_ROUNDS];
  logic             rf_we;
  logic [3:0]       rf_widx;
  logic [0:3][31:0] rf_wdata;
  logic [0:3][31:0] round_key_q, round_key_d;
  logic             rk_valid_q, rk_valid_d;
  logic [3:0]       rd_eff;
  logic             rd_ok;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rf_we    = 1'b0;
    rf_widx  = cnt_q;
    rf_wdata = next_round(rf_q[cnt_q - 4'd1], rcon(cnt_q));
    // A load restarts expansion from any state, discarding partial results.
    if (kif.key_load_i) begin
      state_d  = S_EXPAND;
      cnt_d    = 4'd1;
      rf_we    = 1'b1;
      rf_widx  = 4'd0;
      rf_wdata = kif.cipher_key_i;
    end else begin
      case (state_q)
        S_EXPAND: begin
          rf_we = 1'b1;
          if (cnt_q == c_LAST) begin
            state_d = S_READY;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_eff      = kif.rk_reverse_i ? (c_LAST - kif.rk_round_i) : kif.rk_round_i;
    // key_ready falls at a load edge, so a read on that edge is refused.
    rd_ok       = kif.rk_req_i && (state_q == S_READY) && !kif.key_load_i
                  && (kif.rk_round_i <= c_LAST);
    rk_valid_d  = rd_ok;
    round_key_d = round_key_q;
    if (kif.rk_req_i) begin
      round_key_d = '0;
      if (rd_ok) begin
        round_key_d = rf_q[rd_eff];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      round_key_q <= '0;
      rk_valid_q  <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      round_key_q <= round_key_d;
      rk_valid_q  <= rk_valid_d;
      if (rf_we) begin
        rf_q[rf_widx] <= rf_wdata;
      end
    end
  end

  assign kif.key_ready_o = (state_q == S_READY);
  assign kif.round_key_o = round_key_q;
  assign kif.rk_valid_o  = rk_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_key_schedule_store.sv
`default_nettype none
// ============================================================================
// tb_key_schedule_store : randomized scoreboard bench for key_schedule_store
// Revision: 1.0
// ============================================================================
module tb_key_schedule_store;

  localparam logic [127:0] c_KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] c_KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] c_A_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] c_A_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] c_B_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0;
  logic n_rst;

  key_schedule_store_if kif ();

  key_schedule_store #(.NUM_ROUNDS(10)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .kif   (kif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         valid;
    logic [127:0] data;
  } exp_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  exp_t         exp_q[$];
  logic [7:0]   sbox_m [256];
  logic [127:0] rk_m   [11];
  logic         ready_m  = 1'b0;
  logic         loaded_m = 1'b0;
  int           since_m  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: S-box derived from GF(2^8) inverse plus affine map,
  // then the textbook 44-word key expansion.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    return (v << s) | (v >> (8 - s));
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then
  // compare key_ready shortly after.
  task automatic tick();
    @(posedge clk);
    if (!n_rst) begin
      ready_m  = 1'b0;
      loaded_m = 1'b0;
    end else if (kif.key_load_i) begin
      expand(kif.cipher_key_i);
      loaded_m = 1'b1;
      ready_m  = 1'b0;
      since_m  = 0;
    end else if (loaded_m && !ready_m) begin
      since_m++;
      if (since_m == 10) ready_m = 1'b1;
    end
    #1;
    check("key_ready", 128'(kif.key_ready_o), 128'(ready_m));
  endtask

  task automatic req(input logic [3:0] rnd, input logic rev);
    exp_t e;
    int   eff;
    eff = rev ? (10 - int'(rnd)) : int'(rnd);
    kif.rk_req_i     = 1'b1;
    kif.rk_round_i   = rnd;
    kif.rk_reverse_i = rev;
    e.valid = n_rst && ready_m && !kif.key_load_i && (rnd <= 4'd10);
    e.data  = e.valid ? rk_m[eff] : 128'h0;
    exp_q.push_back(e);
  endtask

  task automatic req_const(input logic [3:0] rnd, input logic rev, input logic [127:0] data);
    exp_t e;
    kif.rk_req_i     = 1'b1;
    kif.rk_round_i   = rnd;
    kif.rk_reverse_i = rev;
    e.valid = 1'b1;
    e.data  = data;
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [127:0] key);
    kif.key_load_i   = 1'b1;
    kif.cipher_key_i = key;
    tick();
    kif.key_load_i   = 1'b0;
  endtask

  initial begin : monitor
    logic seen;
    exp_t e;
    forever begin
      @(posedge clk);
      seen = kif.rk_req_i;
      @(negedge clk);
      if (seen) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard: read observed with no expectation queued (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("rk_valid", 128'(kif.rk_valid_o), 128'(e.valid));
          check("round_key", 128'(kif.round_key_o), e.data);
        end
      end else begin
        check("rk_valid_idle", 128'(kif.rk_valid_o), 128'h0);
      end
    end
  end

  initial begin : stimulus
    n_rst            = 1'b0;
    kif.key_load_i   = 1'b0;
    kif.cipher_key_i = '0;
    kif.rk_req_i     = 1'b0;
    kif.rk_round_i   = '0;
    kif.rk_reverse_i = 1'b0;
    build_sbox();

    repeat (3) tick();
    check("reset_round_key", 128'(kif.round_key_o), 128'h0);
    check("reset_rk_valid", 128'(kif.rk_valid_o), 128'h0);
    n_rst = 1'b1;
    tick();

    // Expansion of key A with reads refused throughout.
    load(c_KEY_A);
    for (int i = 0; i < 10; i++) begin
      req(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      tick();
    end
    kif.rk_req_i = 1'b0;

    req_const(4'd1, 1'b0, c_A_R1);   tick();
    req_const(4'd10, 1'b0, c_A_R10); tick();
    req_const(4'd0, 1'b1, c_A_R10);  tick();
    req_const(4'd10, 1'b1, c_KEY_A); tick();
    req(4'd11, 1'b0); tick();
    req(4'd15, 1'b0); tick();
    req(4'd11, 1'b1); tick();
    for (int r = 0; r <= 10; r++) begin
      req(4'(r), 1'b1);
      tick();
    end
    kif.rk_req_i = 1'b0;
    tick();

    // Reload with key B at the fourth cycle of an expansion.
    load(c_KEY_A);
    repeat (3) tick();
    load(c_KEY_B);
    repeat (10) tick();
    req_const(4'd10, 1'b0, c_B_R10); tick();
    req_const(4'd0, 1'b1, c_B_R10);  tick();
    req(4'd3, 1'b0);                 tick();
    kif.rk_req_i = 1'b0;

    // Reset in the middle of an expansion.
    load(c_KEY_A);
    repeat (5) tick();
    n_rst = 1'b0;
    tick();
    check("midreset_round_key", 128'(kif.round_key_o), 128'h0);
    check("midreset_rk_valid", 128'(kif.rk_valid_o), 128'h0);
    n_rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      req(4'($urandom_range(0, 10)), 1'($urandom_range(0, 1)));
      tick();
    end
    kif.rk_req_i = 1'b0;

    // Read coinciding with a load while ready.
    load(c_KEY_B);
    repeat (10) tick();
    req(4'd5, 1'b0);
    tick();
    kif.key_load_i   = 1'b1;
    kif.cipher_key_i = c_KEY_A;
    req(4'd3, 1'b0);
    tick();
    kif.key_load_i = 1'b0;
    kif.rk_req_i   = 1'b0;
    repeat (10) tick();

    // Randomized traffic: occasional loads and resets amid random reads.
    for (int i = 0; i < 400; i++) begin
      n_rst          = ($urandom_range(0, 199) != 0);
      kif.key_load_i = ($urandom_range(0, 99) < 4);
      if (kif.key_load_i) kif.cipher_key_i = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) != 0) req(4'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
      else kif.rk_req_i = 1'b0;
      tick();
    end
    n_rst          = 1'b1;
    kif.key_load_i = 1'b0;
    kif.rk_req_i   = 1'b0;
    repeat (3) tick();
    check("scoreboard_drained", 128'(exp_q.size()), 128'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
